// File: rtl/sr_seq_ctrl_if.sv
// Host/detector-side signal bundle for sr_seq_ctrl.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready handshake; results are strobed and never stalled.
interface sr_seq_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              sr_din;
  logic              sr_match;
  logic              busy;
  logic              res_valid;
  logic              res_match;
  logic [DATA_W-1:0] res_data;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  byte_cnt;
  logic              clr_cnt;

  // Host and detector model side.
  modport master (
    output in_valid, in_data, sr_match, clr_cnt,
    input  in_ready, sr_din, busy, res_valid, res_match, res_data, hit_cnt, byte_cnt
  );

  // Controller side.
  modport slave (
    input  in_valid, in_data, sr_match, clr_cnt,
    output in_ready, sr_din, busy, res_valid, res_match, res_data, hit_cnt, byte_cnt
  );
endinterface

// File: rtl/sr_seq_ctrl.sv
// Serialises accepted bytes MSB-first into the sequence detector and reports its match flag.
// Latency: result sampled DATA_W+MATCH_LAT edges after accept, strobed the following cycle.
// Backpressure: in_ready only in IDLE; one byte in flight, GAP idle cycles between bytes.
module sr_seq_ctrl #(
  parameter int DATA_W    = 8,
  parameter int MATCH_LAT = 2,
  parameter int GAP       = 4,
  parameter int CNT_W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  sr_seq_ctrl_if.slave bus
);

  localparam int IDX_W = (DATA_W > 1)    ? $clog2(DATA_W)    : 1;
  localparam int LAT_W = (MATCH_LAT > 1) ? $clog2(MATCH_LAT) : 1;
  localparam int GAP_W = (GAP > 1)       ? $clog2(GAP)       : 1;

  localparam logic [IDX_W-1:0] IDX_INIT = IDX_W'(DATA_W - 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MATCH_LAT - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam bit               HAS_GAP  = (GAP > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_dec;
  logic [LAT_W-1:0]  lat_q;
  logic [GAP_W-1:0]  gap_q;
  logic              sr_din_q;
  logic              res_valid_q;
  logic              res_match_q;
  logic [DATA_W-1:0] res_data_q;
  logic [CNT_W-1:0]  hit_cnt_q;
  logic [CNT_W-1:0]  byte_cnt_q;
  logic              in_ready_c;
  logic              busy_c;
  logic              sample;

  assign idx_dec = idx_q - 1'b1;

  // The match flag is taken on the last edge of CHECK; this also drives the counters.
  assign sample = (state_q == ST_CHECK) && (lat_q == '0);

  // State register; reset aborts any byte in flight on the same edge.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.in_valid) state_d = ST_SHIFT;
      ST_SHIFT: if (idx_q == '0)  state_d = ST_CHECK;
      ST_CHECK: if (lat_q == '0)  state_d = HAS_GAP ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gap_q == '0)  state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Handshake/status outputs decoded purely from the state register.
  always_comb begin
    in_ready_c = (state_q == ST_IDLE);
    busy_c     = (state_q != ST_IDLE);
  end

  // Datapath: byte capture, serial bit register, latency/gap counters and result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q      <= '0;
      idx_q       <= '0;
      lat_q       <= '0;
      gap_q       <= '0;
      sr_din_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_match_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            data_q   <= bus.in_data;
            idx_q    <= IDX_INIT;
            // MSB goes out during the cycle right after the accept edge.
            sr_din_q <= bus.in_data[DATA_W-1];
          end
        end
        ST_SHIFT: begin
          if (idx_q == '0) begin
            // Zero fill after the last bit cannot complete a pattern ending in ones.
            sr_din_q <= 1'b0;
            lat_q    <= LAT_INIT;
          end else begin
            idx_q    <= idx_dec;
            sr_din_q <= data_q[idx_dec];
          end
        end
        ST_CHECK: begin
          if (lat_q == '0) begin
            res_valid_q <= 1'b1;
            res_match_q <= bus.sr_match;
            res_data_q  <= data_q;
            gap_q       <= GAP_INIT;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_q != '0) gap_q <= gap_q - 1'b1;
        end
        default: sr_din_q <= 1'b0;
      endcase
    end
  end

  // Counters: byte count wraps, hit count saturates; a clear beats a same-edge increment.
  always_ff @(posedge clk) begin
    if (rst || bus.clr_cnt) begin
      hit_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else if (sample) begin
      byte_cnt_q <= byte_cnt_q + 1'b1;
      if (bus.sr_match && !(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_c;
  assign bus.sr_din    = sr_din_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_match = res_match_q;
  assign bus.res_data  = res_data_q;
  assign bus.hit_cnt   = hit_cnt_q;
  assign bus.byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_sr_seq_ctrl.sv
// Directed bench for sr_seq_ctrl: two instances (CNT_W=8 and CNT_W=2) share all inputs.
// Each instance feeds a detector model matching serial pattern 101111, one register of delay.
// Expected values are hand-computed constants per directed step.
module tb_sr_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       clr_cnt;

  int checks   = 0;
  int failures = 0;

  sr_seq_ctrl_if #(.DATA_W(8), .CNT_W(8)) bus0 ();
  sr_seq_ctrl_if #(.DATA_W(8), .CNT_W(2)) bus1 ();

  sr_seq_ctrl #(.DATA_W(8), .MATCH_LAT(2), .GAP(4), .CNT_W(8)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  sr_seq_ctrl #(.DATA_W(8), .MATCH_LAT(2), .GAP(4), .CNT_W(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  assign bus0.in_valid = in_valid;
  assign bus0.in_data  = in_data;
  assign bus0.clr_cnt  = clr_cnt;
  assign bus1.in_valid = in_valid;
  assign bus1.in_data  = in_data;
  assign bus1.clr_cnt  = clr_cnt;

  // Detector models: shift sr_din each edge, flag registered one edge after the pattern lands.
  logic [7:0] sh0 = 8'd0;
  logic [7:0] sh1 = 8'd0;
  logic       m0  = 1'b0;
  logic       m1  = 1'b0;

  always @(posedge clk) begin
    sh0 <= {sh0[6:0], bus0.sr_din};
    m0  <= (sh0[5:0] == 6'b101111);
    sh1 <= {sh1[6:0], bus1.sr_din};
    m1  <= (sh1[5:0] == 6'b101111);
  end

  assign bus0.sr_match = m0;
  assign bus1.sr_match = m1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for in_ready, then present one byte for a single accept edge.
  task automatic offer(input logic [7:0] b);
    for (int i = 0; i < 40 && !bus0.in_ready; i++) @(negedge clk);
    chk("ready_wait", bus0.in_ready, 1);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called just after the accept edge E0: checks serial bits, latency and the result.
  task automatic wait_res(input logic [7:0] exp_data, input logic exp_match,
                          input logic [7:0] eh0, input logic [7:0] eb0,
                          input logic [1:0] eh1, input logic [1:0] eb1,
                          input logic clr);
    logic [7:0] cap;
    int         lat;
    cap = 8'd0;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k < 8) cap = {cap[6:0], bus0.sr_din};
      if (k == 8) chk("sr_din_fill", bus0.sr_din, 0);
      if (k == 9 && clr) clr_cnt = 1'b1;
      if (bus0.res_valid) begin
        lat = k;
        break;
      end
    end
    clr_cnt = 1'b0;
    chk("sr_din_bits", cap, exp_data);
    chk("res_latency", lat, 10);
    chk("res_match", bus0.res_match, exp_match);
    chk("res_data", bus0.res_data, exp_data);
    chk("busy_at_res", bus0.busy, 1);
    chk("hit_cnt", bus0.hit_cnt, eh0);
    chk("byte_cnt", bus0.byte_cnt, eb0);
    chk("hit_cnt_w2", bus1.hit_cnt, eh1);
    chk("byte_cnt_w2", bus1.byte_cnt, eb1);
    chk("res_valid_w2", bus1.res_valid, 1);
    @(negedge clk);
    chk("res_pulse", bus0.res_valid, 0);
    chk("res_hold", bus0.res_data, exp_data);
  endtask

  initial begin
    int         low;
    int         hi;
    logic       rm;
    logic [7:0] rd;
    logic       seen;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    clr_cnt  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Reset state.
    chk("rst_in_ready", bus0.in_ready, 1);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_sr_din", bus0.sr_din, 0);
    chk("rst_res_valid", bus0.res_valid, 0);
    chk("rst_res_match", bus0.res_match, 0);
    chk("rst_res_data", bus0.res_data, 0);
    chk("rst_hit_cnt", bus0.hit_cnt, 0);
    chk("rst_byte_cnt", bus0.byte_cnt, 0);

    // 47 = 00101111 matches.
    offer(8'd47);
    chk("busy_after_accept", bus0.busy, 1);
    wait_res(8'd47, 1'b1, 8'd1, 8'd1, 2'd1, 2'd1, 1'b0);

    // 46 and 63 do not match.
    offer(8'd46);
    wait_res(8'd46, 1'b0, 8'd1, 8'd2, 2'd1, 2'd2, 1'b0);
    offer(8'd63);
    wait_res(8'd63, 1'b0, 8'd1, 8'd3, 2'd1, 2'd3, 1'b0);

    // Back-to-back with in_valid held: 175 then 191, second accept 15 edges later.
    for (int i = 0; i < 40 && !bus0.in_ready; i++) @(negedge clk);
    chk("ready_wait_b2b", bus0.in_ready, 1);
    in_valid = 1'b1;
    in_data  = 8'd175;
    @(posedge clk);
    #1 in_data = 8'd191;
    low  = 0;
    hi   = -1;
    rm   = 1'b0;
    rd   = 8'd0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus0.res_valid) begin
        rm = bus0.res_match;
        rd = bus0.res_data;
      end
      if (bus0.in_ready) begin
        hi = k;
        break;
      end
      low++;
    end
    chk("b2b_ready_low", low, 14);
    chk("b2b_ready_edge", hi, 14);
    chk("b2b_res1_match", rm, 1);
    chk("b2b_res1_data", rd, 175);
    chk("b2b_hit_cnt", bus0.hit_cnt, 2);
    chk("b2b_byte_cnt", bus0.byte_cnt, 4);
    chk("b2b_byte_cnt_w2", bus1.byte_cnt, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_res(8'd191, 1'b0, 8'd2, 8'd5, 2'd2, 2'd1, 1'b0);

    // Reset during SHIFT of 111 (after E4).
    offer(8'd111);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", bus0.in_ready, 1);
    chk("midrst_busy", bus0.busy, 0);
    chk("midrst_sr_din", bus0.sr_din, 0);
    chk("midrst_hit_cnt", bus0.hit_cnt, 0);
    chk("midrst_byte_cnt", bus0.byte_cnt, 0);
    seen = bus0.res_valid;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (bus0.res_valid) seen = 1'b1;
    end
    chk("midrst_no_result", seen, 0);
    offer(8'd111);
    wait_res(8'd111, 1'b1, 8'd1, 8'd1, 2'd1, 2'd1, 1'b0);

    // 239 five times: narrow counters saturate / wrap.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    offer(8'd239);
    wait_res(8'd239, 1'b1, 8'd1, 8'd1, 2'd1, 2'd1, 1'b0);
    offer(8'd239);
    wait_res(8'd239, 1'b1, 8'd2, 8'd2, 2'd2, 2'd2, 1'b0);
    offer(8'd239);
    wait_res(8'd239, 1'b1, 8'd3, 8'd3, 2'd3, 2'd3, 1'b0);
    offer(8'd239);
    wait_res(8'd239, 1'b1, 8'd4, 8'd4, 2'd3, 2'd0, 1'b0);
    offer(8'd239);
    wait_res(8'd239, 1'b1, 8'd5, 8'd5, 2'd3, 2'd1, 1'b0);

    // Clear on the same edge as a matching result: clear wins, result still reported.
    offer(8'd47);
    wait_res(8'd47, 1'b1, 8'd0, 8'd0, 2'd0, 2'd0, 1'b1);
    offer(8'd46);
    wait_res(8'd46, 1'b0, 8'd0, 8'd1, 2'd0, 2'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_seq_ctrl.md
# sr_seq_ctrl

Sequencing controller for the serial sequence-detector shift register. It accepts parallel bytes over a valid/ready handshake and shifts each byte MSB-first into the detector's serial input. After the detector's output latency it samples the match flag and reports a per-byte result. It also keeps hit and byte counters and enforces an idle gap between bytes. It sits between the switch/host logic and the `shift_reg` detector instance.

## Interface
- `DATA_W`, 8, bits per byte shifted into the detector
- `MATCH_LAT`, 2, edges after the final shift edge before `sr_match` is valid to sample (≥1)
- `GAP`, 4, idle cycles after each result before accepting the next byte (≥0)
- `CNT_W`, 8, width of `hit_cnt` and `byte_cnt`

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  byte offered
- `in_data`  in  DATA_W  byte to test
- `in_ready`  out  1  controller can accept (IDLE only)
- `sr_din`  out  1  serial bit to detector `din`
- `sr_match`  in  1  detector match flag (detector `out` reduced to match/no-match)
- `busy`  out  1  high in any state except IDLE
- `res_valid`  out  1  one-cycle result strobe
- `res_match`  out  1  sampled match for the last byte; held until next result
- `res_data`  out  DATA_W  byte the result belongs to; held until next result
- `hit_cnt`  out  CNT_W  bytes that matched, saturating
- `byte_cnt`  out  CNT_W  bytes completed, wrapping
- `clr_cnt`  in  1  synchronous clear of both counters

## Operation
- Four states: IDLE, SHIFT, CHECK, GAP.
- IDLE: `in_ready`=1, `sr_din`=0. Edge with `in_valid&in_ready` latches `in_data` into the data register, sets bit index to DATA_W-1, and goes to SHIFT.
- SHIFT: `sr_din` = data[index], registered so it is stable for the whole cycle. Index decrements each edge. The edge on which index==0 goes to CHECK with latency counter = MATCH_LAT-1.
- CHECK: `sr_din`=0. Latency counter decrements each edge. The edge on which it is 0 latches `sr_match` into `res_match` and data into `res_data`, sets `res_valid`=1 for the next cycle, updates the counters, and goes to GAP (or IDLE if GAP==0).
- GAP: `sr_din`=0. Counts GAP cycles, then goes to IDLE.
- Trailing zeros cannot complete a pattern ending in 1s, so zero fill between bytes never causes false matches. Each byte fully flushes an 8-bit detector, so no detector clear is needed.
- Counters: `byte_cnt` increments by 1 per result and wraps at 2^CNT_W. `hit_cnt` increments when the sampled match is 1 and saturates at all-ones. If `clr_cnt` and an increment occur on the same edge, clear wins and both counters become 0.
- `in_valid` is ignored outside IDLE; there is no buffering. `in_data` changes while busy have no effect.

## Timing
- Reset: state IDLE, `sr_din`=0, `in_ready`=1, `busy`=0, `res_valid`=0, `res_match`=0, `res_data`=0, both counters 0.
- Reset mid-operation (any state) aborts the byte within the same edge. No result is produced and counters are cleared.
- Accept edge E0. Bit DATA_W-1-k is on `sr_din` between edges Ek and E(k+1), so the detector samples bits at E1..E(DATA_W).
- `sr_match` is sampled at E(DATA_W+MATCH_LAT). `res_valid` is high during the following cycle; with defaults, sampled at E10 and strobed after E10.
- `busy` rises after E0 and falls after E(DATA_W+MATCH_LAT+GAP).
- Earliest next accept edge is E(DATA_W+MATCH_LAT+GAP+1): 15 with defaults. Period is 15 cycles per byte with `in_valid` held high.

## Test plan
- Reset, then offer 8'd47 once → `sr_din` shows 0,0,1,0,1,1,1,1 on E1..E8; `res_valid` pulses after E10; `res_match`=1, `res_data`=47, `hit_cnt`=1, `byte_cnt`=1.
- Offer 8'd46, then 8'd63 → both `res_match`=0, `hit_cnt` unchanged, `byte_cnt` +2.
- Hold `in_valid`=1 with 175 then 191 → second accept exactly 15 cycles after the first; results are 1 then 0; `in_ready` is low for the 14 busy cycles in between.
- Assert `rst` during SHIFT (after E4 of 8'd111) → next cycle IDLE, `sr_din`=0, no `res_valid`, counters 0. Re-offering 111 then gives match=1.
- With CNT_W=2, send 239 five times → `hit_cnt` sequence 1,2,3,3,3; `byte_cnt` sequence 1,2,3,0,1.
- Pulse `clr_cnt` on the same edge as a matching result → `hit_cnt`=0 and `byte_cnt`=0 after that edge; `res_valid`/`res_match`=1 still reported.
